present_ctr_ctrl: RTL and testbench

- Counter-mode controller that sits directly around the PRESENT-80 encryption core.
- Upstream, it accepts 64-bit plaintext/ciphertext words on a valid/ready stream and feeds counter blocks plus the key into the core.
- Downstream, it consumes the core's output block and XORs it with the buffered data word. The result goes out on a valid/ready stream.
- It owns the core's reset, start and handshake sequencing. The core parks in its final state with done held high until reset, so this block issues one core reset per block.

---
 rtl/present_pkg.sv | 16 +
 rtl/present_ctr_inc.sv | 26 ++
 rtl/present_ctr_ctrl.sv | 148 ++++++++++++++
 tb/tb_present_ctr_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared types and sizes for the PRESENT-80 counter-mode controller.
package present_pkg;

    localparam int KEY_W       = 80;
    localparam int BLK_W       = 64;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        LAUNCH,
        WAIT,
        OUT
    } ctr_state_t;

endpackage

// File: rtl/present_ctr_inc.sv
// Increments the low CTR_BITS of a counter block; carry marks a wrap.
module present_ctr_inc
    import present_pkg::*;
#(
    parameter int CTR_BITS = 32
) (
    input  logic [BLK_W-1:0] ctr,
    output logic [BLK_W-1:0] ctr_nxt,
    output logic             carry
);

    logic [CTR_BITS:0] sum;

    assign sum   = {1'b0, ctr[CTR_BITS-1:0]} + {{CTR_BITS{1'b0}}, 1'b1};
    assign carry = sum[CTR_BITS];

    generate
        if (CTR_BITS < BLK_W) begin : g_part
            // upper bits are the fixed nonce
            assign ctr_nxt = {ctr[BLK_W-1:CTR_BITS], sum[CTR_BITS-1:0]};
        end else begin : g_full
            assign ctr_nxt = sum[BLK_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/present_ctr_ctrl.sv
// Counter-mode controller around a PRESENT-80 core: one core reset,
// start and wait per block, keystream XORed with the buffered word.
module present_ctr_ctrl
    import present_pkg::*;
#(
    parameter int CTR_BITS = 32,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [KEY_W-1:0] key_in,
    input  logic [BLK_W-1:0] iv_in,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BLK_W-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [BLK_W-1:0] m_data,
    output logic             m_last,
    output logic             core_rst,
    output logic             core_start,
    output logic [BLK_W-1:0] core_din,
    output logic [KEY_W-1:0] core_key,
    input  logic [BLK_W-1:0] core_dout,
    input  logic             core_done,
    output logic             busy,
    output logic             wrap,
    output logic             err
);

    localparam int TW = $clog2(TIMEOUT + 1) + 1;

    ctr_state_t       state;
    ctr_state_t       state_nxt;
    logic             keyed;
    logic [BLK_W-1:0] ctr;
    logic [BLK_W-1:0] ctr_inc;
    logic             ctr_carry;
    logic [KEY_W-1:0] key_reg;
    logic [BLK_W-1:0] pt;
    logic             last;
    logic [TW-1:0]    tcnt;
    logic             accept;
    logic             tmo;

    present_ctr_inc #(
        .CTR_BITS(CTR_BITS)
    ) u_inc (
        .ctr    (ctr),
        .ctr_nxt(ctr_inc),
        .carry  (ctr_carry)
    );

    assign tmo      = (tcnt == TW'(TIMEOUT));
    assign core_din = ctr;
    assign core_key = key_reg;
    assign busy     = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        accept     = 1'b0;
        core_rst   = 1'b0;
        core_start = 1'b0;
        unique case (state)
            IDLE: begin
                core_rst = 1'b1;
                s_ready  = keyed && !load;
                accept   = s_valid && keyed && !load;
                if (accept) state_nxt = CRST;
            end
            CRST: begin
                core_rst  = 1'b1;
                state_nxt = LAUNCH;
            end
            LAUNCH: begin
                core_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (core_done) state_nxt = OUT;
                else if (tmo)  state_nxt = CRST;
            end
            OUT: begin
                if (m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            keyed   <= 1'b0;
            ctr     <= '0;
            key_reg <= '0;
            pt      <= '0;
            last    <= 1'b0;
            tcnt    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            wrap    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        key_reg <= key_in;
                        ctr     <= iv_in;
                        keyed   <= 1'b1;
                        wrap    <= 1'b0;
                        err     <= 1'b0;
                    end
                    if (accept) begin
                        pt   <= s_data;
                        last <= s_last;
                    end
                end
                LAUNCH: tcnt <= '0;
                WAIT: begin
                    tcnt <= tcnt + TW'(1);
                    if (core_done) begin
                        m_data  <= pt ^ core_dout;
                        m_last  <= last;
                        m_valid <= 1'b1;
                        ctr     <= ctr_inc;
                        if (ctr_carry) wrap <= 1'b1;
                    end else if (tmo) begin
                        // drop the block; same pt and ctr are retried
                        err <= 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) m_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_present_ctr_ctrl.sv
// Bench for present_ctr_ctrl with a behavioural PRESENT-80 core stub.
module tb_present_ctr_ctrl;

    localparam int CTR_BITS = 32;
    localparam int TIMEOUT  = 64;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        load = 1'b0;
    logic [79:0] key_in = '0;
    logic [63:0] iv_in = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [63:0] m_data;
    logic        m_last;
    logic        core_rst;
    logic        core_start;
    logic [63:0] core_din;
    logic [79:0] core_key;
    logic [63:0] core_dout = '0;
    logic        core_done = 1'b0;
    logic        busy;
    logic        wrap;
    logic        err;

    present_ctr_ctrl #(
        .CTR_BITS(CTR_BITS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .key_in    (key_in),
        .iv_in     (iv_in),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .core_rst  (core_rst),
        .core_start(core_start),
        .core_din  (core_din),
        .core_key  (core_key),
        .core_dout (core_dout),
        .core_done (core_done),
        .busy      (busy),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] present_enc(input logic [63:0] p, input logic [79:0] key);
        logic [63:0] s;
        logic [63:0] t;
        logic [79:0] k;
        s = p;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[n*4 +: 4] = sbox(s[n*4 +: 4]);
            t = '0;
            for (int b = 0; b < 63; b++) t[(b * 16) % 63] = s[b];
            t[63] = s[63];
            s = t;
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // core stub: result after lat cycles, done held until core_rst
    int          lat  = 3;
    bit          hang = 1'b0;
    int          c_cnt = 0;
    logic [63:0] c_res = '0;

    always @(posedge CLK) begin
        if (core_rst) begin
            core_done <= 1'b0;
            c_cnt     <= 0;
        end else if (core_start) begin
            c_res <= present_enc(core_din, core_key);
            c_cnt <= lat;
        end else if (c_cnt > 0) begin
            c_cnt <= c_cnt - 1;
            if (c_cnt == 1 && !hang) begin
                core_done <= 1'b1;
                core_dout <= c_res;
            end
        end
    end

    int          nstart = 0;
    logic [63:0] last_din = '0;
    always @(posedge CLK) begin
        if (core_start) begin
            nstart   = nstart + 1;
            last_din = core_din;
        end
    end

    // reference model state
    logic [79:0] mkey  = '0;
    logic [63:0] mctr  = '0;
    bit          mwrap = 1'b0;

    function automatic logic [63:0] low_mask();
        if (CTR_BITS >= 64) return '1;
        return (64'd1 << CTR_BITS) - 64'd1;
    endfunction

    task automatic model_block(input logic [63:0] d, output logic [63:0] exp, output logic [63:0] din);
        logic [63:0] mk;
        mk  = low_mask();
        din = mctr;
        exp = d ^ present_enc(mctr, mkey);
        if ((mctr & mk) == mk) mwrap = 1'b1;
        mctr = (mctr & ~mk) | ((mctr + 64'd1) & mk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        total++;
        bad++;
        $display("FAIL %s timed out", nm);
    endtask

    task automatic do_load(input logic [79:0] k, input logic [63:0] iv);
        load   = 1'b1;
        key_in = k;
        iv_in  = iv;
        @(negedge CLK);
        chk("sready_during_load", s_ready, 0);
        @(posedge CLK); #1;
        load = 1'b0;
        mkey = k;
        mctr = iv;
        mwrap = 1'b0;
    endtask

    task automatic xfer(input logic [63:0] d, input logic l, input int hold, input bit poke,
                        output logic [63:0] got, output logic gotl);
        logic [63:0] held;
        int st0;
        bit ok;
        got  = '0;
        gotl = 1'b0;
        m_ready = (hold == 0);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            if (s_ready) begin ok = 1; break; end
        end
        if (!ok) begin fail_to("accept"); s_valid = 1'b0; m_ready = 1'b1; return; end
        @(posedge CLK); #1;
        s_valid = 1'b0;
        s_data  = {$urandom, $urandom};
        s_last  = 1'($urandom);
        if (poke) begin
            ok = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge CLK);
                if (core_start) begin ok = 1; break; end
            end
            if (!ok) fail_to("poke_start");
            @(posedge CLK); #1;
            load   = 1'b1;
            key_in = ~mkey;
            iv_in  = ~mctr;
            @(posedge CLK); #1;
            load = 1'b0;
        end
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (m_valid) begin ok = 1; break; end
        end
        if (!ok) begin fail_to("m_valid"); m_ready = 1'b1; return; end
        if (hold > 0) begin
            held = m_data;
            st0  = nstart;
            for (int i = 0; i < hold; i++) begin
                @(negedge CLK);
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, held);
                chk("hold_sready", s_ready, 0);
            end
            chk("hold_nostart", 64'(nstart), 64'(st0));
            @(posedge CLK); #1;
            m_ready = 1'b1;
            @(negedge CLK);
        end
        got  = m_data;
        gotl = m_last;
        @(posedge CLK); #1;
    endtask

    typedef struct {
        logic [79:0] key;
        logic [63:0] iv;
        logic [63:0] data;
        logic        last;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [63:0] got, exp, din;
        logic        gotl;
        int          n;
        bit          ok;
        int          st0;

        vecs[0] = '{80'h0, 64'h0, 64'h0, 1'b0, 64'h5579C1387B228445};
        vecs[1] = '{{80{1'b1}}, 64'h0, 64'h0, 1'b1, 64'hE72C46C0F5945049};
        vecs[2] = '{80'h0, 64'h0, {64{1'b1}}, 1'b1, 64'hAA863EC784DD7BBA};
        vecs[3] = '{80'h0, 64'h0, 64'hAA863EC784DD7BBA, 1'b0, {64{1'b1}}};

        RST = 1'b1;
        s_valid = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_core_start", core_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_err", err, 0);
        @(posedge CLK); #1;
        s_valid = 1'b0;

        for (int i = 0; i < 4; i++) begin
            do_load(vecs[i].key, vecs[i].iv);
            model_block(vecs[i].data, exp, din);
            xfer(vecs[i].data, vecs[i].last, 0, 0, got, gotl);
            chk($sformatf("vec%0d_data", i), got, vecs[i].exp);
            chk($sformatf("vec%0d_last", i), gotl, vecs[i].last);
            chk($sformatf("vec%0d_din", i), last_din, vecs[i].iv);
        end

        // counter advances to 1 after the first block from iv 0
        do_load(80'h0, 64'h0);
        model_block(64'h0, exp, din);
        xfer(64'h0, 1'b0, 0, 0, got, gotl);
        model_block(64'h0, exp, din);
        xfer(64'h0, 1'b0, 0, 0, got, gotl);
        chk("ctr1_din", last_din, 64'h1);
        chk("ctr1_data", got, exp);

        // low-field wrap
        lat = 2;
        do_load({16'($urandom), $urandom, $urandom}, 64'h12345678FFFFFFFF);
        model_block(64'h1111, exp, din);
        xfer(64'h1111, 1'b0, 0, 0, got, gotl);
        chk("wrap_first_din", last_din, 64'h12345678FFFFFFFF);
        chk("wrap_first_data", got, exp);
        chk("wrap_set", wrap, 1);
        model_block(64'h2222, exp, din);
        xfer(64'h2222, 1'b1, 0, 0, got, gotl);
        chk("wrap_second_din", last_din, 64'h1234567800000000);
        chk("wrap_second_data", got, exp);
        chk("wrap_sticky", wrap, 1);

        // backpressure hold, then a load during WAIT that must be ignored
        model_block(64'hDEADBEEFCAFEF00D, exp, din);
        xfer(64'hDEADBEEFCAFEF00D, 1'b1, 10, 0, got, gotl);
        chk("hold_out_data", got, exp);
        chk("hold_out_last", gotl, 1);
        lat = 6;
        model_block(64'h0123456789ABCDEF, exp, din);
        xfer(64'h0123456789ABCDEF, 1'b0, 0, 1, got, gotl);
        chk("poke_data", got, exp);
        model_block(64'h5A5A5A5A5A5A5A5A, exp, din);
        xfer(64'h5A5A5A5A5A5A5A5A, 1'b0, 0, 0, got, gotl);
        chk("poke_next_data", got, exp);
        chk("poke_next_din", last_din, din);

        // randomized traffic against the model
        for (int i = 0; i < 20; i++) begin
            logic [63:0] d;
            logic        l;
            if ($urandom_range(0, 3) == 0)
                do_load({16'($urandom), $urandom, $urandom},
                        {$urandom, ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFE : $urandom});
            lat = $urandom_range(1, 8);
            d = {$urandom, $urandom};
            l = 1'($urandom);
            model_block(d, exp, din);
            xfer(d, l, $urandom_range(0, 3), 0, got, gotl);
            chk($sformatf("rnd%0d_data", i), got, exp);
            chk($sformatf("rnd%0d_last", i), gotl, l);
            chk($sformatf("rnd%0d_din", i), last_din, din);
            chk($sformatf("rnd%0d_wrap", i), wrap, mwrap);
        end

        // core timeout, retry, then reset mid-WAIT
        hang = 1'b1;
        lat  = 3;
        do_load({16'($urandom), $urandom, $urandom}, {$urandom, $urandom});
        s_valid = 1'b1;
        s_data  = 64'hFEEDFACE00000001;
        ok = 0;
        for (n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (s_ready) begin ok = 1; break; end
        end
        if (!ok) fail_to("to_accept");
        @(posedge CLK); #1;
        s_valid = 1'b0;
        ok = 0;
        for (n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (core_start) begin ok = 1; break; end
        end
        if (!ok) fail_to("to_start");
        ok = 0;
        for (n = 1; n < 300; n++) begin
            @(negedge CLK);
            if (err) begin ok = 1; break; end
        end
        if (!ok) fail_to("to_err");
        chk("to_cycles", 64'(n), 64'(TIMEOUT + 2));
        chk("to_m_valid", m_valid, 0);
        chk("to_core_rst", core_rst, 1);
        st0 = nstart;
        ok = 0;
        for (n = 0; n < 5; n++) begin
            @(negedge CLK);
            if (core_start) begin ok = 1; break; end
        end
        if (!ok) fail_to("retry_start");
        chk("retry_din", core_din, mctr);
        repeat (3) @(negedge CLK);
        chk("retry_busy", busy, 1);
        chk("retry_count", 64'(nstart), 64'(st0 + 1));
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST  = 1'b0;
        hang = 1'b0;
        @(negedge CLK);
        chk("rst2_s_ready", s_ready, 0);
        chk("rst2_m_valid", m_valid, 0);
        chk("rst2_m_data", m_data, 0);
        chk("rst2_m_last", m_last, 0);
        chk("rst2_core_rst", core_rst, 1);
        chk("rst2_core_start", core_start, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_wrap", wrap, 0);
        chk("rst2_err", err, 0);
        st0 = nstart;
        @(posedge CLK); #1;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("unkeyed_s_ready", s_ready, 0);
            chk("unkeyed_busy", busy, 0);
        end
        @(posedge CLK); #1;
        s_valid = 1'b0;
        chk("unkeyed_nostart", 64'(nstart), 64'(st0));
        do_load(80'h0, 64'h0);
        @(negedge CLK);
        chk("reload_s_ready", s_ready, 1);
        @(posedge CLK); #1;
        model_block(64'h0, exp, din);
        xfer(64'h0, 1'b1, 0, 0, got, gotl);
        chk("reload_data", got, 64'h5579C1387B228445);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
